spi_if_rw: RTL and testbench

Parametrised SPI slave that replaces the read-only 5-bit/16-bit interface. It adds a read/write command bit, generic address and data widths, auto-incrementing burst transfers with address wrap-around, write strobes to the register/memory block, and a sticky error flag for aborted frames and alarms. It sits between the external SPI master pins and the on-chip memory/register block, and runs entirely in the `sck` domain. SPI modes 00/11 only: all sampling and updates occur on rising `sck`.

---
 rtl/spi_if_rw.sv | 185 ++++++++++++++++++
 tb/tb_spi_if_rw.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_if_rw.sv
// spi_if_rw: SPI slave for modes 00/11 with a read/write command bit,
// generic address/data widths, burst transfers with optional address
// auto-increment, write strobes and a sticky error flag. All logic runs
// on rising sck; cs_n is sampled synchronously.
//
// Frame layout (cs_n low): 1 command bit (1 = read), ADDR_W address bits,
// then any number of DATA_W-bit words, everything MSB first.
// Read words cost DATA_W+1 edges (one RD fetch edge with sdo = 0);
// write words cost DATA_W edges with no gap.
//
// Memory handshake (no back-pressure, the memory must always accept):
//   - read:  rd_en_o is high for exactly the RD cycle; data_mem_i and
//            alarm_sig_i are sampled on the sck edge that ends it.
//   - write: wr_en_o, wr_data_o and addr_mem_o form a one-cycle request;
//            the memory commits it on the sck edge that ends that cycle.
//   - addr_mem_o is only meaningful while rd_en_o or wr_en_o is high.
module spi_if_rw #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 16,
    parameter int AUTO_INC = 1
) (
    input  logic              sck,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              sdi,
    output logic              sdo,
    output logic              err_flag,
    input  logic [DATA_W-1:0] data_mem_i,
    input  logic              alarm_sig_i,
    output logic [ADDR_W-1:0] addr_mem_o,
    output logic              rd_en_o,
    output logic              wr_en_o,
    output logic [DATA_W-1:0] wr_data_o
);

    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W);
    localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_STEP = (AUTO_INC != 0) ? ADDR_W'(1) : '0;

    typedef enum logic [2:0] {
        ST_CMD  = 3'd0,
        ST_ADDR = 3'd1,
        ST_RD   = 3'd2,
        ST_TX   = 3'd3,
        ST_RX   = 3'd4
    } state_t;

    state_t            state_q,   state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] shreg_q,   shreg_d;
    logic              rw_q,      rw_d;
    logic              sdo_q,     sdo_d;
    logic              wr_en_q,   wr_en_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              err_q,     err_d;

    logic [ADDR_W-1:0] addr_shift;
    logic [DATA_W-1:0] shreg_shift;
    logic [DATA_W-1:0] tx_word;

    // Next-state and next-output logic for the whole frame sequencer.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        addr_d      = addr_q;
        shreg_d     = shreg_q;
        rw_d        = rw_q;
        sdo_d       = sdo_q;
        wr_en_d     = 1'b0;
        wr_data_d   = wr_data_q;
        err_d       = err_q;

        addr_shift  = (addr_q << 1) | ADDR_W'(sdi);
        shreg_shift = (shreg_q << 1) | DATA_W'(sdi);
        tx_word     = shreg_q << bit_cnt_q;

        // The pending write is committed by the memory on this edge, so the
        // address moves on whether or not the frame continues.
        if (wr_en_q) begin
            addr_d = addr_q + ADDR_STEP;
        end

        if (cs_n) begin
            state_d   = ST_CMD;
            bit_cnt_d = '0;
            sdo_d     = 1'b0;
            // Deselect in the middle of the address or of a data word.
            if ((state_q == ST_ADDR) ||
                (((state_q == ST_TX) || (state_q == ST_RX)) && (bit_cnt_q != '0))) begin
                err_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_CMD: begin
                    rw_d      = sdi;
                    err_d     = 1'b0;
                    sdo_d     = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = ST_ADDR;
                end
                ST_ADDR: begin
                    addr_d = addr_shift;
                    sdo_d  = 1'b0;
                    if (bit_cnt_q == ADDR_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = rw_q ? ST_RD : ST_RX;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                    end
                end
                ST_RD: begin
                    shreg_d = data_mem_i;
                    if (!alarm_sig_i) begin
                        err_d = 1'b1;
                    end
                    sdo_d     = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = ST_TX;
                end
                ST_TX: begin
                    sdo_d = tx_word[DATA_W-1];
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        addr_d    = addr_q + ADDR_STEP;
                        state_d   = ST_RD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                    end
                end
                ST_RX: begin
                    shreg_d = shreg_shift;
                    sdo_d   = 1'b0;
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        wr_en_d   = 1'b1;
                        wr_data_d = shreg_shift;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d   = ST_CMD;
                    bit_cnt_d = '0;
                end
            endcase
        end
    end

    // State and registered outputs; reset clears a frame in progress at once.
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CMD;
            bit_cnt_q <= '0;
            addr_q    <= '0;
            shreg_q   <= '0;
            rw_q      <= 1'b0;
            sdo_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            addr_q    <= addr_d;
            shreg_q   <= shreg_d;
            rw_q      <= rw_d;
            sdo_q     <= sdo_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
        end
    end

    assign sdo        = sdo_q;
    assign err_flag   = err_q;
    assign addr_mem_o = addr_q;
    assign rd_en_o    = (state_q == ST_RD);
    assign wr_en_o    = wr_en_q;
    assign wr_data_o  = wr_data_q;

endmodule

// File: tb/tb_spi_if_rw.sv
// Bench for spi_if_rw: two instances (AUTO_INC = 1 and 0) share the SPI
// pins; each reads from its own view of a shared ROM. A frame-level model
// predicts every output after every sck edge from the edge number.
module tb_spi_if_rw;

    localparam int AW = 5;
    localparam int D  = 16;

    logic sck = 1'b0;
    logic rst_n;
    logic cs_n;
    logic sdi;
    logic alarm;

    logic          sdo_w   [2];
    logic          err_w   [2];
    logic          rd_w    [2];
    logic          wr_w    [2];
    logic [AW-1:0] addr_w  [2];
    logic [D-1:0]  wdata_w [2];
    logic [D-1:0]  rdat_w  [2];

    logic [D-1:0]  rom [32];

    assign rdat_w[0] = rom[addr_w[0]];
    assign rdat_w[1] = rom[addr_w[1]];

    spi_if_rw #(.ADDR_W(AW), .DATA_W(D), .AUTO_INC(1)) u_inc (
        .sck(sck), .rst_n(rst_n), .cs_n(cs_n), .sdi(sdi),
        .sdo(sdo_w[0]), .err_flag(err_w[0]),
        .data_mem_i(rdat_w[0]), .alarm_sig_i(alarm),
        .addr_mem_o(addr_w[0]), .rd_en_o(rd_w[0]),
        .wr_en_o(wr_w[0]), .wr_data_o(wdata_w[0])
    );

    spi_if_rw #(.ADDR_W(AW), .DATA_W(D), .AUTO_INC(0)) u_fix (
        .sck(sck), .rst_n(rst_n), .cs_n(cs_n), .sdi(sdi),
        .sdo(sdo_w[1]), .err_flag(err_w[1]),
        .data_mem_i(rdat_w[1]), .alarm_sig_i(alarm),
        .addr_mem_o(addr_w[1]), .rd_en_o(rd_w[1]),
        .wr_en_o(wr_w[1]), .wr_data_o(wdata_w[1])
    );

    // Clock.
    always #5 sck = ~sck;

    // Current frame descriptor and position (cur_k = last edge number,
    // 0 when idle between frames).
    bit            f_rw;
    bit            f_alarm_low;
    logic [AW-1:0] f_addr;
    int            f_n;
    int            cur_k;
    bit            prev_err;
    bit            chk_en;

    int n_pass;
    int n_tot;

    // Write-data scoreboard: words the master fully shifted in, in order.
    logic [D-1:0] exp_q [$];

    // Per-frame observations for the literal checks.
    logic [D-1:0]  cap_sdo;
    logic [AW-1:0] rd_aq0 [$];
    logic [AW-1:0] rd_aq1 [$];
    int            wr_cnt;
    logic [AW-1:0] wr_addr_last;
    logic [D-1:0]  wr_data_last;
    logic          err_k1;
    logic          err_pre;
    logic          err_cap;

    task automatic chk(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s[%0d] k=%0d: got %0h, expected %0h", name, inst, cur_k, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int step_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    function automatic logic [AW-1:0] word_addr(input int i, input int w);
        return AW'(int'(f_addr) + w * step_of(i));
    endfunction

    // Fetch cycles: right after the last address bit, then every D+1 edges.
    function automatic bit m_rd(input int k);
        return f_rw && (k >= AW + 1) && (k <= f_n) && (((k - (AW + 1)) % (D + 1)) == 0);
    endfunction

    function automatic int m_rd_word(input int k);
        return (k - (AW + 1)) / (D + 1);
    endfunction

    function automatic bit m_sdo(input int i, input int k);
        int p;
        logic [D-1:0] sh;
        if (!f_rw || (k < AW + 3) || (k > f_n)) return 1'b0;
        p = k - (AW + 3);
        if ((p % (D + 1)) == D) return 1'b0;
        sh = rom[word_addr(i, p / (D + 1))] >> (D - 1 - (p % (D + 1)));
        return sh[0];
    endfunction

    // Write strobe after each complete word of D data bits.
    function automatic bit m_wr(input int k);
        return !f_rw && (k <= f_n) && (k >= AW + 1 + D) && (((k - (AW + 1)) % D) == 0);
    endfunction

    function automatic int m_wr_word(input int k);
        return (k - (AW + 1)) / D - 1;
    endfunction

    function automatic bit m_abort(input int n);
        int q;
        if ((n >= 1) && (n <= AW)) return 1'b1;
        if (f_rw) begin
            if (n < AW + 2) return 1'b0;
            q = (n - (AW + 2)) % (D + 1);
            return (q != 0) && (q != D);
        end
        if (n < AW + 1) return 1'b0;
        return ((n - (AW + 1)) % D) != 0;
    endfunction

    function automatic bit m_err(input int k);
        if (k == 0) return prev_err;
        if (k <= f_n) return f_rw && f_alarm_low && (k >= AW + 2);
        return (f_rw && f_alarm_low && (f_n >= AW + 2)) || m_abort(f_n);
    endfunction

    // ---------------- compare process ----------------
    always @(negedge sck) begin
        if (cur_k == 1) begin
            rd_aq0.delete();
            rd_aq1.delete();
            wr_cnt  = 0;
            cap_sdo = '0;
            err_k1  = err_w[0];
        end
        if (cur_k == AW + 1) err_pre = err_w[0];
        if (cur_k == AW + 2) err_cap = err_w[0];
        if ((cur_k >= 1) && (cur_k < f_n)) begin
            if (rd_w[0]) rd_aq0.push_back(addr_w[0]);
            if (rd_w[1]) rd_aq1.push_back(addr_w[1]);
        end
        if ((cur_k >= AW + 3) && (cur_k <= AW + 2 + D)) cap_sdo = {cap_sdo[D-2:0], sdo_w[0]};
        if (wr_w[0]) begin
            wr_cnt++;
            wr_addr_last = addr_w[0];
            wr_data_last = wdata_w[0];
        end

        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("sdo", i, sdo_w[i], m_sdo(i, cur_k));
                chk("rd_en", i, rd_w[i], m_rd(cur_k));
                chk("wr_en", i, wr_w[i], m_wr(cur_k));
                chk("err_flag", i, err_w[i], m_err(cur_k));
                if (m_rd(cur_k)) chk("rd_addr", i, addr_w[i], word_addr(i, m_rd_word(cur_k)));
                if (m_wr(cur_k)) begin
                    chk("wr_addr", i, addr_w[i], word_addr(i, m_wr_word(cur_k)));
                    if (exp_q.size() != 0) begin
                        chk("wr_data", i, wdata_w[i], exp_q[0]);
                    end else begin
                        n_tot++;
                        $display("FAIL wr_data[%0d] k=%0d: got %0h, expected no write", i, cur_k, wdata_w[i]);
                    end
                end
            end
            if (m_wr(cur_k) && (exp_q.size() != 0)) void'(exp_q.pop_front());
        end
    end

    // ---------------- driver ----------------
    task automatic do_frame(input bit rw, input logic [AW-1:0] a, input int n,
                            input bit alarm_low, input logic [D-1:0] w0, input int rst_at);
        logic [D-1:0] wd [$];
        logic [D-1:0] sh;
        logic [AW-1:0] ash;
        int j;
        wd.push_back(w0);
        for (int w = 1; w < 10; w++) wd.push_back(D'($urandom));
        if (!rw) begin
            for (int w = 0; w < 10; w++) begin
                if (AW + 1 + D * (w + 1) <= n) exp_q.push_back(wd[w]);
            end
        end
        f_rw        = rw;
        f_addr      = a;
        f_n         = n;
        f_alarm_low = alarm_low;
        for (int k = 1; k <= n; k++) begin
            cs_n  = 1'b0;
            alarm = !alarm_low;
            if (k == 1) begin
                sdi = rw;
            end else if (k <= AW + 1) begin
                ash = a >> (AW - 1 - (k - 2));
                sdi = ash[0];
            end else if (!rw) begin
                j   = k - (AW + 2);
                sh  = wd[j / D] >> (D - 1 - (j % D));
                sdi = sh[0];
            end else begin
                sdi = 1'($urandom_range(0, 1));
            end
            @(posedge sck);
            #1;
            cur_k = k;
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                for (int i = 0; i < 2; i++) begin
                    chk("rst_sdo", i, sdo_w[i], 1'b0);
                    chk("rst_err", i, err_w[i], 1'b0);
                    chk("rst_rd_en", i, rd_w[i], 1'b0);
                    chk("rst_wr_en", i, wr_w[i], 1'b0);
                end
                cur_k    = 0;
                prev_err = 1'b0;
                cs_n     = 1'b1;
                alarm    = 1'b1;
                repeat (2) @(posedge sck);
                #1;
                rst_n = 1'b1;
                return;
            end
        end
        cs_n  = 1'b1;
        alarm = 1'b1;
        sdi   = 1'b0;
        @(posedge sck);
        #1;
        cur_k = n + 1;
        @(posedge sck);
        #1;
        prev_err = m_err(n + 1);
        cur_k    = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n    = 1'b0;
        cs_n     = 1'b1;
        sdi      = 1'b0;
        alarm    = 1'b1;
        cur_k    = 0;
        f_n      = 0;
        f_rw     = 1'b0;
        f_addr   = '0;
        prev_err = 1'b0;
        chk_en   = 1'b0;
        n_pass   = 0;
        n_tot    = 0;
        for (int i = 0; i < 32; i++) rom[AW'(i)] = D'($urandom);
        rom[3] = 16'hA5C3;

        repeat (3) @(posedge sck);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_sdo", i, sdo_w[i], 1'b0);
            chk("reset_err", i, err_w[i], 1'b0);
            chk("reset_rd_en", i, rd_w[i], 1'b0);
            chk("reset_wr_en", i, wr_w[i], 1'b0);
            chk("reset_wr_data", i, wdata_w[i], 16'h0000);
            chk("reset_addr", i, addr_w[i], 5'h00);
        end
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(posedge sck);
        #1;

        // Single read of address 3.
        do_frame(1'b1, 5'h03, AW + 1 + (D + 1), 1'b0, 16'h0000, 0);
        chk("read_bits", 0, cap_sdo, 16'hA5C3);
        chk("read_rd_count", 0, rd_aq0.size(), 1);
        if (rd_aq0.size() >= 1) chk("read_rd_addr", 0, rd_aq0[0], 5'h03);
        chk("read_err", 0, err_w[0], 1'b0);

        // Single write of 16'h1234 to address 5'h1E.
        do_frame(1'b0, 5'h1E, AW + 1 + D, 1'b0, 16'h1234, 0);
        chk("write_count", 0, wr_cnt, 1);
        chk("write_addr", 0, wr_addr_last, 5'h1E);
        chk("write_data", 0, wr_data_last, 16'h1234);

        // Three-word burst read from the top address.
        do_frame(1'b1, 5'h1F, AW + 1 + 3 * (D + 1), 1'b0, 16'h0000, 0);
        chk("burst_inc_count", 0, rd_aq0.size(), 3);
        chk("burst_fix_count", 1, rd_aq1.size(), 3);
        if (rd_aq0.size() == 3) begin
            chk("burst_inc_a0", 0, rd_aq0[0], 5'd31);
            chk("burst_inc_a1", 0, rd_aq0[1], 5'd0);
            chk("burst_inc_a2", 0, rd_aq0[2], 5'd1);
        end
        if (rd_aq1.size() == 3) begin
            chk("burst_fix_a0", 1, rd_aq1[0], 5'd31);
            chk("burst_fix_a1", 1, rd_aq1[1], 5'd31);
            chk("burst_fix_a2", 1, rd_aq1[2], 5'd31);
        end

        // Write aborted after 7 data bits; flag holds until next command.
        do_frame(1'b0, 5'h0A, AW + 1 + 7, 1'b0, 16'hBEEF, 0);
        chk("abort_no_write", 0, wr_cnt, 0);
        chk("abort_err_held", 0, err_w[0], 1'b1);
        do_frame(1'b1, 5'h03, AW + 1 + (D + 1), 1'b0, 16'h0000, 0);
        chk("abort_err_cleared", 0, err_k1, 1'b0);

        // Read with the alarm asserted.
        do_frame(1'b1, 5'h03, AW + 1 + (D + 1), 1'b1, 16'h0000, 0);
        chk("alarm_err_before", 0, err_pre, 1'b0);
        chk("alarm_err_capture", 0, err_cap, 1'b1);
        chk("alarm_bits", 0, cap_sdo, 16'hA5C3);

        // Reset in the middle of a transmitted word, then a clean read.
        do_frame(1'b1, 5'h03, AW + 1 + 2 * (D + 1), 1'b1, 16'h0000, AW + 8);
        do_frame(1'b1, 5'h03, AW + 1 + (D + 1), 1'b0, 16'h0000, 0);
        chk("post_reset_bits", 0, cap_sdo, 16'hA5C3);

        // Random frames, complete or cut short.
        for (int f = 0; f < 40; f++) begin
            bit rw;
            int nw;
            int full;
            int n;
            rw   = 1'($urandom_range(0, 1));
            nw   = $urandom_range(1, 3);
            full = rw ? (AW + 1 + nw * (D + 1)) : (AW + 1 + nw * D);
            n    = ($urandom_range(0, 2) == 0) ? $urandom_range(1, full) : full;
            do_frame(rw, AW'($urandom), n, rw && ($urandom_range(0, 4) == 0), D'($urandom), 0);
        end

        chk("wr_queue_drained", 0, exp_q.size(), 0);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
